l2_flush_seq: RTL and testbench
===============================

// Module: l2_flush_seq
// PURPOSE
//  Sequences a full L2 flush. Walks every (set, way) pair, reads line state, and issues a writeback/evict request for each dirty line.
//  Sits between the L2 control FSM and the tag/state array read port and eviction request path.
//  Replaces ad-hoc set/clr/incr flush strobes with a self-contained walker.
//  Also throttles on free request-buffer entries and drains outstanding evictions before signalling done.
// PARAMETERS
//  L2_SETS   256  number of sets; power of 2, >=2
//  L2_WAYS   8    number of ways; power of 2, >=2
//  N_REQS    4    request-buffer entries; bounds outstanding evictions
// PORTS
//  clk            in   1                  clock, rising edge
//  rst            in   1                  reset; asynchronous, active-high
//  flush_start    in   1                  1-cycle pulse; starts flush when idle
//  flush_busy     out  1                  high from cycle after accepted start through done cycle
//  flush_done     out  1                  1-cycle pulse; flush complete
//  rd_valid       out  1                  tag/state read request
//  rd_ready       in   1                  read port accepts request
//  rd_set         out  $clog2(L2_SETS)    set index of read
//  rd_way         out  $clog2(L2_WAYS)    way index of read
//  rd_resp_valid  in   1                  read response, >=1 cycle after accept
//  rd_resp_dirty  in   1                  line valid and dirty/owned; sampled with rd_resp_valid
//  evict_valid    out  1                  eviction request
//  evict_ready    in   1                  eviction path accepts request
//  evict_set      out  $clog2(L2_SETS)    set of evicted line; equals rd_set
//  evict_way      out  $clog2(L2_WAYS)    way of evicted line; equals rd_way
//  evict_ack      in   1                  1-cycle pulse; one outstanding eviction retired
//  outstanding    out  $clog2(N_REQS)+1   evictions issued but not yet acked
//  evict_cnt      out  $clog2(L2_SETS*L2_WAYS)+1  evictions issued this flush
// BEHAVIOUR
//  Reset: all outputs 0; FSM enters IDLE.
//  FSM states: IDLE, READ, WAIT, EVICT, NEXT, DRAIN, DONE.
//  IDLE: on flush_start -> READ; clear set, way and evict_cnt. flush_start in any other state is ignored.
//  READ: rd_valid=1. rd_set/rd_way are stable until accepted. On rd_valid&&rd_ready -> WAIT.
//  WAIT: on rd_resp_valid: if dirty -> EVICT, else -> NEXT.
//  EVICT: evict_valid = (outstanding < N_REQS). On evict_valid&&evict_ready -> NEXT, and evict_cnt += 1.
//  NEXT (1 cycle):
//   - way < L2_WAYS-1: way += 1, -> READ.
//   - otherwise way = 0; if set == L2_SETS-1 -> DRAIN, else set += 1, -> READ.
//   - Counters never wrap past the last set/way.
//  DRAIN: wait for outstanding == 0, then -> DONE.
//  DONE: flush_done=1 for exactly one cycle, then -> IDLE. flush_busy drops in the following cycle.
//  outstanding: +1 on evict handshake, -1 on evict_ack. If both occur in the same cycle it is unchanged. It never exceeds N_REQS.
//  An evict_ack with outstanding == 0 is illegal; the counter saturates at 0.
//  Minimum cost per clean line: 3 cycles (READ, WAIT, NEXT) with zero-wait handshakes.
//  Asynchronous rst mid-flush: immediate return to IDLE and all counters cleared. No done pulse.
// CONFIGURATION
//  L2_FLUSH_ABORT_EN defined:
//   - Adds port flush_abort (in, 1) and output flush_aborted (out, 1).
//   - flush_abort is sticky-captured while busy. It is acted on at the next NEXT state: -> DRAIN instead of advancing.
//   - The current line's eviction always completes first.
//   - flush_aborted pulses together with flush_done.
//   - flush_abort in IDLE is ignored. The captured abort is cleared in DONE.
//  L2_FLUSH_ABORT_EN undefined: ports absent; every flush walks all lines.
// TESTING (use L2_SETS=4, L2_WAYS=2, N_REQS=2)
//  1. All clean, ready tied 1, resp 1 cycle after accept:
//     -> 8 reads in order (0,0),(0,1),(1,0)...(3,1); flush_done 1 cycle after last NEXT+DRAIN; evict_cnt=0.
//  2. All dirty, evict_ready=1, no evict_ack for first 20 cycles:
//     -> evict_valid stalls after 2 evictions (outstanding=2); resumes on each ack; done only after 8 acks; evict_cnt=8.
//  3. rd_ready low 5 cycles in READ:
//     -> rd_set/rd_way stable throughout; no advance until handshake.
//  4. flush_start pulsed while busy:
//     -> ignored; exactly one flush_done.
//  5. rst asserted in WAIT at set 2:
//     -> next cycle flush_busy=0, rd_valid=0, counters 0; a later flush_start restarts at (0,0).
//  6. [L2_FLUSH_ABORT_EN] abort pulsed during EVICT of (1,1):
//     -> that eviction completes; no read of (2,0); flush_done and flush_aborted pulse together.

Source files
------------

// File: rtl/l2_flush_seq_if.sv
// Handshake bundle between the L2 flush walker (master) and the L2 control/tag/evict side (slave).
// L2_FLUSH_ABORT_EN adds the flush_abort / flush_aborted pair.
interface l2_flush_seq_if #(
  parameter int unsigned L2_SETS = 256,
  parameter int unsigned L2_WAYS = 8,
  parameter int unsigned N_REQS  = 4
);
  localparam int unsigned SET_W = $clog2(L2_SETS);
  localparam int unsigned WAY_W = $clog2(L2_WAYS);
  localparam int unsigned OUT_W = $clog2(N_REQS) + 1;
  localparam int unsigned CNT_W = $clog2(L2_SETS * L2_WAYS) + 1;

  logic             flush_start;
  logic             flush_busy;
  logic             flush_done;
  logic             rd_valid;
  logic             rd_ready;
  logic [SET_W-1:0] rd_set;
  logic [WAY_W-1:0] rd_way;
  logic             rd_resp_valid;
  logic             rd_resp_dirty;
  logic             evict_valid;
  logic             evict_ready;
  logic [SET_W-1:0] evict_set;
  logic [WAY_W-1:0] evict_way;
  logic             evict_ack;
  logic [OUT_W-1:0] outstanding;
  logic [CNT_W-1:0] evict_cnt;
`ifdef L2_FLUSH_ABORT_EN
  logic             flush_abort;
  logic             flush_aborted;

  modport master (
    input  flush_start, rd_ready, rd_resp_valid, rd_resp_dirty, evict_ready, evict_ack, flush_abort,
    output flush_busy, flush_done, rd_valid, rd_set, rd_way, evict_valid, evict_set, evict_way,
           outstanding, evict_cnt, flush_aborted
  );
  modport slave (
    output flush_start, rd_ready, rd_resp_valid, rd_resp_dirty, evict_ready, evict_ack, flush_abort,
    input  flush_busy, flush_done, rd_valid, rd_set, rd_way, evict_valid, evict_set, evict_way,
           outstanding, evict_cnt, flush_aborted
  );
`else
  modport master (
    input  flush_start, rd_ready, rd_resp_valid, rd_resp_dirty, evict_ready, evict_ack,
    output flush_busy, flush_done, rd_valid, rd_set, rd_way, evict_valid, evict_set, evict_way,
           outstanding, evict_cnt
  );
  modport slave (
    output flush_start, rd_ready, rd_resp_valid, rd_resp_dirty, evict_ready, evict_ack,
    input  flush_busy, flush_done, rd_valid, rd_set, rd_way, evict_valid, evict_set, evict_way,
           outstanding, evict_cnt
  );
`endif
endinterface

// File: rtl/l2_flush_seq.sv
// Full L2 flush walker: reads every (set, way), evicts dirty lines under a request-buffer credit
// limit, drains outstanding evictions, then pulses done. L2_FLUSH_ABORT_EN enables early abort.
module l2_flush_seq #(
  parameter int unsigned L2_SETS = 256,
  parameter int unsigned L2_WAYS = 8,
  parameter int unsigned N_REQS  = 4
) (
  input  logic           clk,
  input  logic           rst,
  l2_flush_seq_if.master bus
);
  localparam int unsigned SET_W = $clog2(L2_SETS);
  localparam int unsigned WAY_W = $clog2(L2_WAYS);
  localparam int unsigned OUT_W = $clog2(N_REQS) + 1;
  localparam int unsigned CNT_W = $clog2(L2_SETS * L2_WAYS) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_EVICT, S_NEXT, S_DRAIN, S_DONE
  } state_t;

  state_t           state_q;
  logic [SET_W-1:0] set_q;
  logic [WAY_W-1:0] way_q;
  logic [OUT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q, rd_valid_q, evict_valid_q;
  logic             rd_hs, ev_hs, ack_ok, last_way, last_set, credit_d, abort_now;

`ifdef L2_FLUSH_ABORT_EN
  logic             abort_q, aborted_q;
  assign abort_now = abort_q | bus.flush_abort;
`else
  assign abort_now = 1'b0;
`endif

  assign rd_hs    = rd_valid_q & bus.rd_ready;
  assign ev_hs    = evict_valid_q & bus.evict_ready;
  assign ack_ok   = bus.evict_ack & (outst_q != '0);
  assign last_way = (way_q == WAY_W'(L2_WAYS - 1));
  assign last_set = (set_q == SET_W'(L2_SETS - 1));
  assign credit_d = (outst_d < OUT_W'(N_REQS));

  // Outstanding evictions: simultaneous issue and retire cancel; a stray ack at zero is dropped.
  always_comb begin
    outst_d = outst_q;
    if (ev_hs && !ack_ok)
      outst_d = outst_q + OUT_W'(1);
    else if (!ev_hs && ack_ok)
      outst_d = outst_q - OUT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      set_q         <= '0;
      way_q         <= '0;
      outst_q       <= '0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_valid_q    <= 1'b0;
      evict_valid_q <= 1'b0;
`ifdef L2_FLUSH_ABORT_EN
      abort_q       <= 1'b0;
      aborted_q     <= 1'b0;
`endif
    end else begin
      outst_q <= outst_d;
      done_q  <= 1'b0;
`ifdef L2_FLUSH_ABORT_EN
      aborted_q <= 1'b0;
      if (state_q != S_IDLE && bus.flush_abort)
        abort_q <= 1'b1;
`endif
      case (state_q)
        S_IDLE: begin
          if (bus.flush_start) begin
            state_q    <= S_READ;
            busy_q     <= 1'b1;
            rd_valid_q <= 1'b1;
            set_q      <= '0;
            way_q      <= '0;
            cnt_q      <= '0;
          end
        end
        S_READ: begin
          if (rd_hs) begin
            rd_valid_q <= 1'b0;
            state_q    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.rd_resp_valid) begin
            if (bus.rd_resp_dirty) begin
              state_q       <= S_EVICT;
              evict_valid_q <= credit_d;
            end else begin
              state_q <= S_NEXT;
            end
          end
        end
        // evict_valid tracks the credit check each cycle so it reflects outstanding < N_REQS.
        S_EVICT: begin
          if (ev_hs) begin
            evict_valid_q <= 1'b0;
            cnt_q         <= cnt_q + CNT_W'(1);
            state_q       <= S_NEXT;
          end else begin
            evict_valid_q <= credit_d;
          end
        end
        S_NEXT: begin
          if (abort_now) begin
            state_q <= S_DRAIN;
          end else if (!last_way) begin
            way_q      <= way_q + WAY_W'(1);
            rd_valid_q <= 1'b1;
            state_q    <= S_READ;
          end else begin
            way_q <= '0;
            if (last_set) begin
              state_q <= S_DRAIN;
            end else begin
              set_q      <= set_q + SET_W'(1);
              rd_valid_q <= 1'b1;
              state_q    <= S_READ;
            end
          end
        end
        S_DRAIN: begin
          if (outst_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
`ifdef L2_FLUSH_ABORT_EN
            aborted_q <= abort_q;
`endif
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
`ifdef L2_FLUSH_ABORT_EN
          abort_q <= 1'b0;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.flush_busy  = busy_q;
  assign bus.flush_done  = done_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_set      = set_q;
  assign bus.rd_way      = way_q;
  assign bus.evict_valid = evict_valid_q;
  assign bus.evict_set   = set_q;
  assign bus.evict_way   = way_q;
  assign bus.outstanding = outst_q;
  assign bus.evict_cnt   = cnt_q;
`ifdef L2_FLUSH_ABORT_EN
  assign bus.flush_aborted = aborted_q;
`endif

endmodule

// File: tb/tb_l2_flush_seq.sv
// Scoreboard bench for l2_flush_seq (4 sets, 2 ways, 2 request entries).
// Stimulus queues expected reads/evictions/done records; a negedge monitor pops and compares.
module tb_l2_flush_seq;
  localparam int unsigned SETS = 4;
  localparam int unsigned WAYS = 2;
  localparam int unsigned NREQ = 2;

  typedef struct { int set; int way; } addr_t;
  typedef struct { int cnt; int aborted; } done_t;

  logic clk = 1'b0;
  logic rst;

  l2_flush_seq_if #(.L2_SETS(SETS), .L2_WAYS(WAYS), .N_REQS(NREQ)) bus ();

  l2_flush_seq #(.L2_SETS(SETS), .L2_WAYS(WAYS), .N_REQS(NREQ)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  addr_t  rd_q[$];
  addr_t  ev_q[$];
  done_t  done_q[$];
  logic [7:0] dirty_mask = 8'h00;
  int     ack_block = 0;
  int     done_seen = 0;
  int     acks_total = 0;
  int     tb_out = 0;
  time    start_time = 0;
  time    done_time = 0;
  logic   resp_pend = 1'b0;
  logic   resp_dirty_pend = 1'b0;
  logic   stall_prev = 1'b0;
  int     stall_set = 0;
  int     stall_way = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Responder + monitor: answers reads one cycle after accept, retires evictions, scores outputs.
  always @(negedge clk) begin
    addr_t a;
    done_t d;
    logic  ev;
    if (rst) begin
      tb_out            = 0;
      resp_pend         = 1'b0;
      stall_prev        = 1'b0;
      bus.rd_resp_valid = 1'b0;
      bus.rd_resp_dirty = 1'b0;
      bus.evict_ack     = 1'b0;
    end else begin
      chk("outstanding", int'(bus.outstanding), tb_out);
      bus.rd_resp_valid = resp_pend;
      bus.rd_resp_dirty = resp_pend & resp_dirty_pend;
      resp_pend = 1'b0;

      if (bus.rd_valid) begin
        if (stall_prev) begin
          chk("rd_set_stable", int'(bus.rd_set), stall_set);
          chk("rd_way_stable", int'(bus.rd_way), stall_way);
        end
        if (bus.rd_ready) begin
          chk("read_expected", int'(rd_q.size() > 0), 1);
          if (rd_q.size() > 0) begin
            a = rd_q.pop_front();
            chk("rd_set", int'(bus.rd_set), a.set);
            chk("rd_way", int'(bus.rd_way), a.way);
          end
          resp_pend       = 1'b1;
          resp_dirty_pend = dirty_mask[int'(bus.rd_set) * WAYS + int'(bus.rd_way)];
          stall_prev      = 1'b0;
        end else begin
          stall_prev = 1'b1;
          stall_set  = int'(bus.rd_set);
          stall_way  = int'(bus.rd_way);
        end
      end else begin
        stall_prev = 1'b0;
      end

      if (ack_block > 0) begin
        ack_block--;
        bus.evict_ack = 1'b0;
      end else begin
        bus.evict_ack = (tb_out > 0);
      end
      if (bus.evict_valid)
        chk("evict_credit", int'(bus.outstanding < NREQ), 1);
      ev = bus.evict_valid & bus.evict_ready;
      if (ev) begin
        chk("evict_expected", int'(ev_q.size() > 0), 1);
        if (ev_q.size() > 0) begin
          a = ev_q.pop_front();
          chk("evict_set", int'(bus.evict_set), a.set);
          chk("evict_way", int'(bus.evict_way), a.way);
        end
      end
      tb_out     = tb_out + int'(ev) - int'(bus.evict_ack);
      acks_total = acks_total + int'(bus.evict_ack);

      if (bus.flush_done) begin
        done_seen++;
        done_time = $time;
        chk("done_expected", int'(done_q.size() > 0), 1);
        chk("busy_at_done", int'(bus.flush_busy), 1);
        if (done_q.size() > 0) begin
          d = done_q.pop_front();
          chk("evict_cnt", int'(bus.evict_cnt), d.cnt);
`ifdef L2_FLUSH_ABORT_EN
          chk("flush_aborted", int'(bus.flush_aborted), d.aborted);
`endif
        end
      end
`ifdef L2_FLUSH_ABORT_EN
      else begin
        chk("aborted_only_with_done", int'(bus.flush_aborted), 0);
      end
`endif
    end
  end

  // Queue the reads of the first n_lines lines, the dirty ones among them, and the done record.
  task automatic expect_flush(input logic [7:0] mask, input int n_lines, input int aborted);
    addr_t a;
    done_t d;
    int    cnt = 0;
    for (int i = 0; i < n_lines; i++) begin
      a.set = i / WAYS;
      a.way = i % WAYS;
      rd_q.push_back(a);
      if (mask[i]) begin
        ev_q.push_back(a);
        cnt++;
      end
    end
    d.cnt     = cnt;
    d.aborted = aborted;
    done_q.push_back(d);
  endtask

  task automatic pulse_start();
    bus.flush_start = 1'b1;
    start_time      = $time;
    @(negedge clk);
    bus.flush_start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit);
    int n = 0;
    while (done_seen < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("done_in_time", int'(done_seen >= target), 1);
    @(negedge clk);
    chk("busy_after_done", int'(bus.flush_busy), 0);
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_reads_left"}, int'(rd_q.size()), 0);
    chk({tag, "_evicts_left"}, int'(ev_q.size()), 0);
  endtask

  initial begin
    int n;
    int acks0;
    rst                 = 1'b1;
    bus.flush_start     = 1'b0;
    bus.rd_ready        = 1'b1;
    bus.evict_ready     = 1'b1;
    bus.rd_resp_valid   = 1'b0;
    bus.rd_resp_dirty   = 1'b0;
    bus.evict_ack       = 1'b0;
`ifdef L2_FLUSH_ABORT_EN
    bus.flush_abort     = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.flush_busy), 0);
    chk("rst_done", int'(bus.flush_done), 0);
    chk("rst_rd_valid", int'(bus.rd_valid), 0);
    chk("rst_evict_valid", int'(bus.evict_valid), 0);
    chk("rst_outstanding", int'(bus.outstanding), 0);
    chk("rst_evict_cnt", int'(bus.evict_cnt), 0);
    chk("rst_rd_set", int'(bus.rd_set), 0);
    chk("rst_rd_way", int'(bus.rd_way), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // All clean: 3 cycles per line, done 26 cycles after the start pulse.
    dirty_mask = 8'h00;
    expect_flush(8'h00, 8, 0);
    pulse_start();
    wait_done(1, 200);
    chk("clean_latency", int'((done_time - start_time) / 10), 26);
    check_drained("t1");

    // All dirty with acks withheld: stalls at two outstanding evictions.
    dirty_mask = 8'hFF;
    ack_block  = 20;
    acks0      = acks_total;
    expect_flush(8'hFF, 8, 0);
    pulse_start();
    repeat (13) @(negedge clk);
    chk("stall_outstanding", int'(bus.outstanding), 2);
    chk("stall_evict_valid", int'(bus.evict_valid), 0);
    chk("stall_rd_valid", int'(bus.rd_valid), 0);
    wait_done(2, 400);
    chk("dirty_acks", acks_total - acks0, 8);
    check_drained("t2");

    // Read port back-pressure for 5 cycles, mixed dirty lines, and a start pulse while busy.
    dirty_mask   = 8'h69;
    bus.rd_ready = 1'b0;
    expect_flush(8'h69, 8, 0);
    pulse_start();
    repeat (5) @(negedge clk);
    bus.rd_ready = 1'b1;
    repeat (6) @(negedge clk);
    bus.flush_start = 1'b1;
    @(negedge clk);
    bus.flush_start = 1'b0;
    wait_done(3, 400);
    repeat (20) @(negedge clk);
    chk("single_done", done_seen, 3);
    chk("idle_busy", int'(bus.flush_busy), 0);
    check_drained("t3");

    // Reset while waiting on the read response of set 2, then a clean restart from (0,0).
    dirty_mask = 8'h00;
    expect_flush(8'h00, 8, 0);
    pulse_start();
    n = 0;
    while (!(bus.rd_valid && bus.rd_ready && bus.rd_set == 2'd2) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reached_set2", int'(n < 100), 1);
    @(negedge clk);
    rst = 1'b1;
    rd_q.delete();
    ev_q.delete();
    done_q.delete();
    @(negedge clk);
    chk("mid_rst_busy", int'(bus.flush_busy), 0);
    chk("mid_rst_rd_valid", int'(bus.rd_valid), 0);
    chk("mid_rst_done", int'(bus.flush_done), 0);
    chk("mid_rst_outstanding", int'(bus.outstanding), 0);
    chk("mid_rst_evict_cnt", int'(bus.evict_cnt), 0);
    chk("mid_rst_rd_set", int'(bus.rd_set), 0);
    chk("mid_rst_rd_way", int'(bus.rd_way), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("no_done_on_rst", done_seen, 3);
    expect_flush(8'h00, 8, 0);
    pulse_start();
    wait_done(4, 200);
    check_drained("t5");

`ifdef L2_FLUSH_ABORT_EN
    // Abort raised while evicting (1,1): that eviction completes, walk stops before (2,0).
    dirty_mask = 8'hFF;
    expect_flush(8'hFF, 4, 1);
    pulse_start();
    n = 0;
    while (!(bus.evict_valid && bus.rd_set == 2'd1 && bus.rd_way == 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reached_evict_1_1", int'(n < 200), 1);
    bus.flush_abort = 1'b1;
    @(negedge clk);
    bus.flush_abort = 1'b0;
    wait_done(5, 200);
    check_drained("t6");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
